multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM for the multicycle MIPS data path. Consumes the latched opcode/function fields and the ALU zero flag, and drives every mux select, write enable and ALU opcode of the data path one cycle at a time. Implements fetch/decode and the execution sequences for R-type, lw, sw, beq, bne, addi, ori, j and a GPIO-read instruction.

## Interface
Parameters:
- none (encodings come from the shared package)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; sampled on rising edge of clk
- op  in  6  Instr[31:26] from instruction register
- funct  in  6  Instr[5:0] from instruction register
- zero  in  1  combinational ALU zero flag (ALUResult == 0)
- PCen  out  1  PC register enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALU_o
- IRWrite  out  1  instruction register enable
- MemWrite  out  1  memory write enable
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  write data: 0 = ALU_o, 1 = memory data register
- RegWrite  out  1  register file write enable
- Ori  out  1  immediate source: 0 = Instr[15:0], 1 = GPIO_i
- ALUSrcA  out  1  0 = PC, 1 = A register
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignExt, 11 = SignExt<<2
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCsrc  out  1  0 = ALUResult, 1 = ALU_o
- Jump  out  1  1 = {PC[31:28], Instr[25:0], 2'b00}
- illegal_o  out  1  one-cycle pulse on undecodable instruction

## Operation
- Opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, ori 0x0D, j 0x02, gpin 0x3F. Funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
- Unlisted outputs are 0 in each state. ALUControl defaults to add.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCsrc=0, PCen=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11 (branch target into ALU_o). Next state depends on op: lw/sw -> MEMADR; R -> EXEC_R; beq/bne -> BRANCH; addi -> ADDI_EX; ori -> ORI_EX; gpin -> GPIN_EX; j -> JUMP; else -> FETCH with illegal_o=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10. lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUControl=alu_decoder(funct) -> ALUWB. An unknown funct asserts illegal_o and goes -> FETCH.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, PCsrc=1. PCen=zero for beq and PCen=~zero for bne -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, add -> IMMWB.
- ORI_EX: ALUSrcA=1, ALUSrcB=10, or -> IMMWB. The immediate is sign-extended by the data path.
- GPIN_EX: ALUSrcA=1, ALUSrcB=10, Ori=1, ALUControl=or -> GPIN_WB. This computes rs | GPIO_i.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- GPIN_WB: the same outputs as IMMWB plus Ori=1 -> FETCH.
- JUMP: Jump=1, PCen=1 -> FETCH.

## Timing
- Reset: the state register loads FETCH on the first rising edge with reset=1. While reset=1, all outputs are forced to 0, including PCen, IRWrite, MemWrite, RegWrite and illegal_o. The first FETCH executes in the first cycle after reset deasserts.
- Reset asserted mid-instruction aborts the sequence on the next edge. No write enable is asserted in that cycle.
- Outputs are a combinational decode of the registered state. The exceptions are:
  - PCen in BRANCH, which depends on zero.
  - illegal_o, which depends on op/funct.
  - next-state selection, which depends on op/funct.
- op/funct are stable from DECODE to the end of the instruction because IRWrite is only asserted in FETCH.
- Cycles per instruction, FETCH included: lw 5; sw, R, addi, ori, gpin 4; beq, bne, j 3; illegal 2 (R-type with bad funct 3).
- State encoding is a 4-bit register.
- Unreachable encodings must go -> FETCH on the next edge with all outputs 0.

## Structure
- Package mc_pkg holds:
  - the opcode and funct localparams;
  - the ALUControl codes;
  - the state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, BRANCH, ADDI_EX, ORI_EX, GPIN_EX, IMMWB, GPIN_WB, JUMP.
- Sub-module alu_decoder: combinational, funct -> {ALUControl, valid}. It is used in EXEC_R and is reusable elsewhere.
- The data path must expose the zero flag as a new output wired to this block.

## Test plan
- reset=1 for 2 cycles, then release: all outputs are 0 during reset. The cycle after release shows FETCH outputs (PCen=1, IRWrite=1, ALUSrcB=01).
- op=0x23: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. MemWB cycle shows RegWrite=1, MemtoReg=1, RegDst=0. Total 5 cycles.
- op=0x00, funct=0x22: EXEC_R shows ALUControl=110, ALUSrcA=1, ALUSrcB=00. ALUWB shows RegDst=1, RegWrite=1. With funct=0x3B instead: illegal_o pulses once and the sequence returns to FETCH after 3 cycles.
- Branch PCen truth table, with PCsrc=1 in every case:
  - op=0x04, zero=1: PCen=1 in BRANCH.
  - op=0x04, zero=0: PCen=0.
  - op=0x05: PCen is inverted relative to the op=0x04 cases.
- Jump and GPIO read:
  - op=0x02: JUMP shows Jump=1, PCen=1; 3 cycles total.
  - op=0x3F: GPIN_EX and GPIN_WB both show Ori=1, with RegWrite=1 only in GPIN_WB.
- op=0x2B with reset asserted during MEMADR: MemWrite never asserts, and the state is FETCH after reset releases.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, funct codes,
// ALU operation codes and the control FSM state enumeration.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_GPIN  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC_R  = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDI_EX = 4'd9,
        ORI_EX  = 4'd10,
        GPIN_EX = 4'd11,
        IMMWB   = 4'd12,
        GPIN_WB = 4'd13,
        JUMP    = 4'd14
    } state_t;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct field decoder: maps funct to an ALU operation code and flags
// functs the data path cannot execute.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);

    // Unknown functs report invalid and fall back to add.
    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS data path; outputs decode the state
// register, except branch PCen (zero) and illegal_o (op/funct).
module multicycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCen,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       Ori,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       PCsrc,
    output logic       Jump,
    output logic       illegal_o
);

    state_t     state_r;
    state_t     next_s;
    logic [2:0] dec_alu_s;
    logic       dec_valid_s;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (dec_alu_s),
        .valid       (dec_valid_s)
    );

    // State register; reset restarts at FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Output decode and next-state selection; reset silences every output.
    always_comb begin
        PCen       = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        Ori        = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCsrc      = 1'b0;
        Jump       = 1'b0;
        illegal_o  = 1'b0;
        next_s     = FETCH;
        if (reset) begin
            ALUControl = 3'b000;
        end else begin
            case (state_r)
                FETCH: begin
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCen    = 1'b1;
                    next_s  = DECODE;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    case (op)
                        OP_LW, OP_SW:   next_s = MEMADR;
                        OP_RTYPE:       next_s = EXEC_R;
                        OP_BEQ, OP_BNE: next_s = BRANCH;
                        OP_ADDI:        next_s = ADDI_EX;
                        OP_ORI:         next_s = ORI_EX;
                        OP_GPIN:        next_s = GPIN_EX;
                        OP_J:           next_s = JUMP;
                        default:        illegal_o = 1'b1;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    if (op == OP_LW) begin
                        next_s = MEMRD;
                    end else if (op == OP_SW) begin
                        next_s = MEMWR;
                    end else begin
                        next_s = FETCH;
                    end
                end
                MEMRD: begin
                    IorD   = 1'b1;
                    next_s = MEMWB;
                end
                MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = dec_alu_s;
                    if (dec_valid_s) begin
                        next_s = ALUWB;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_SUB;
                    PCsrc      = 1'b1;
                    PCen       = (op == OP_BNE) ? ~zero : zero;
                end
                ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    next_s  = IMMWB;
                end
                ORI_EX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_OR;
                    next_s     = IMMWB;
                end
                GPIN_EX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    Ori        = 1'b1;
                    ALUControl = ALU_OR;
                    next_s     = GPIN_WB;
                end
                IMMWB: begin
                    RegWrite = 1'b1;
                end
                GPIN_WB: begin
                    RegWrite = 1'b1;
                    Ori      = 1'b1;
                end
                JUMP: begin
                    Jump = 1'b1;
                    PCen = 1'b1;
                end
                default: begin
                    ALUControl = 3'b000;
                    next_s     = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control against a per-instruction
// expected output-sequence model.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcen, iord, irwrite, memwrite, regdst, memtoreg, regwrite, ori, srca;
        logic [1:0] srcb;
        logic [2:0] alu;
        logic       pcsrc, jump, ill;
    } ov_t;
    typedef ov_t ovq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h20;
    logic       zero = 1'b0;
    logic       PCen, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, Ori, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       PCsrc, Jump, illegal_o;
    ov_t        obs;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [5:0] legal_ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h02, 6'h3F};
    logic [5:0] legal_fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCen(PCen), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Ori(Ori),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .PCsrc(PCsrc), .Jump(Jump), .illegal_o(illegal_o)
    );

    assign obs = {PCen, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, Ori,
                  ALUSrcA, ALUSrcB, ALUControl, PCsrc, Jump, illegal_o};

    always #5 clk = ~clk;

    function automatic ov_t idle();
        ov_t w = '0;
        w.alu = 3'b010;
        return w;
    endfunction

    function automatic ov_t fetch_word();
        ov_t w = idle();
        w.pcen = 1'b1; w.irwrite = 1'b1; w.srcb = 2'b01;
        return w;
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    // Expected per-cycle output words for one instruction, FETCH first.
    function automatic ovq_t model(input logic [5:0] o, input logic [5:0] f, input logic z);
        ovq_t q;
        ov_t  w;
        ov_t  ex;
        logic [2:0] ac = 3'b010;
        logic fv = 1'b1;
        q.push_back(fetch_word());
        w = idle(); w.srcb = 2'b11; w.ill = ~is_legal(o);
        q.push_back(w);
        ex = idle(); ex.srca = 1'b1; ex.srcb = 2'b10;
        case (o)
            6'h23: begin
                q.push_back(ex);
                w = idle(); w.iord = 1'b1; q.push_back(w);
                w = idle(); w.memtoreg = 1'b1; w.regwrite = 1'b1; q.push_back(w);
            end
            6'h2B: begin
                q.push_back(ex);
                w = idle(); w.iord = 1'b1; w.memwrite = 1'b1; q.push_back(w);
            end
            6'h00: begin
                case (f)
                    6'h20: ac = 3'b010;
                    6'h22: ac = 3'b110;
                    6'h24: ac = 3'b000;
                    6'h25: ac = 3'b001;
                    6'h2A: ac = 3'b111;
                    default: fv = 1'b0;
                endcase
                w = idle(); w.srca = 1'b1; w.alu = ac; w.ill = ~fv; q.push_back(w);
                if (fv) begin
                    w = idle(); w.regdst = 1'b1; w.regwrite = 1'b1; q.push_back(w);
                end
            end
            6'h04, 6'h05: begin
                w = idle(); w.srca = 1'b1; w.alu = 3'b110; w.pcsrc = 1'b1;
                w.pcen = (o == 6'h04) ? z : ~z;
                q.push_back(w);
            end
            6'h08, 6'h0D: begin
                w = ex; if (o == 6'h0D) w.alu = 3'b001; q.push_back(w);
                w = idle(); w.regwrite = 1'b1; q.push_back(w);
            end
            6'h3F: begin
                w = ex; w.alu = 3'b001; w.ori = 1'b1; q.push_back(w);
                w = idle(); w.regwrite = 1'b1; w.ori = 1'b1; q.push_back(w);
            end
            6'h02: begin
                w = idle(); w.jump = 1'b1; w.pcen = 1'b1; q.push_back(w);
            end
            default: ;
        endcase
        return q;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n_checks++;
            if (obs !== ov_t'('0)) begin
                n_fail++;
                $display("FAIL reset cycle %0d: got %h, expected %h", i, obs, ov_t'('0));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        ovq_t q;
        op = 6'h23; funct = 6'($urandom); zero = 1'($urandom);
        q = model(op, funct, zero);
        foreach (q[i]) begin
            #1;
            n_checks++;
            if (obs !== q[i]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %h, expected %h", i, obs, q[i]);
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (obs !== fetch_word()) begin
            n_fail++;
            $display("FAIL lw_len: got %h, expected fetch %h", obs, fetch_word());
        end
    endtask

    task automatic test_rtype();
        ovq_t q;
        logic [5:0] fns [2] = '{6'h22, 6'h3B};
        for (int k = 0; k < 2; k++) begin
            op = 6'h00; funct = fns[k]; zero = 1'($urandom);
            q = model(op, funct, zero);
            foreach (q[i]) begin
                #1;
                n_checks++;
                if (obs !== q[i]) begin
                    n_fail++;
                    $display("FAIL rtype funct=%h cycle %0d: got %h, expected %h", funct, i, obs, q[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_branch();
        ovq_t q;
        logic [3:0] tt = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            op = k[1] ? 6'h05 : 6'h04; zero = k[0]; funct = 6'($urandom);
            q = model(op, funct, zero);
            foreach (q[i]) begin
                #1;
                n_checks++;
                if (obs !== q[i]) begin
                    n_fail++;
                    $display("FAIL branch op=%h zero=%b cycle %0d: got %h, expected %h", op, zero, i, obs, q[i]);
                end
                if (i == 2) begin
                    n_checks++;
                    if (PCen !== tt[k] || PCsrc !== 1'b1) begin
                        n_fail++;
                        $display("FAIL branch_pcen op=%h zero=%b: got PCen=%b PCsrc=%b, expected PCen=%b PCsrc=1",
                                 op, zero, PCen, PCsrc, tt[k]);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jump_gpin();
        ovq_t q;
        logic [5:0] ops [2] = '{6'h02, 6'h3F};
        for (int k = 0; k < 2; k++) begin
            op = ops[k]; funct = 6'($urandom); zero = 1'($urandom);
            q = model(op, funct, zero);
            foreach (q[i]) begin
                #1;
                n_checks++;
                if (obs !== q[i]) begin
                    n_fail++;
                    $display("FAIL jump_gpin op=%h cycle %0d: got %h, expected %h", op, i, obs, q[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_abort();
        ovq_t q;
        op = 6'h2B; funct = 6'($urandom); zero = 1'($urandom);
        q = model(op, funct, zero);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (obs !== q[i]) begin
                n_fail++;
                $display("FAIL abort cycle %0d: got %h, expected %h", i, obs, q[i]);
            end
            if (i < 2) @(negedge clk);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (obs !== ov_t'('0)) begin
                n_fail++;
                $display("FAIL abort_quiet %0d: got %h, expected %h", i, obs, ov_t'('0));
            end
            if (i == 0) @(negedge clk);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== fetch_word()) begin
            n_fail++;
            $display("FAIL abort_fetch: got %h, expected %h", obs, fetch_word());
        end
    endtask

    task automatic test_random();
        ovq_t q;
        int   r;
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 10));
            if (r < 9) begin
                op = legal_ops[r];
            end else begin
                do op = 6'($urandom); while (is_legal(op));
            end
            funct = ($urandom_range(0, 3) != 0) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
            zero = 1'($urandom);
            q = model(op, funct, zero);
            foreach (q[i]) begin
                #1;
                n_checks++;
                if (obs !== q[i]) begin
                    n_fail++;
                    $display("FAIL random op=%h funct=%h zero=%b cycle %0d: got %h, expected %h",
                             op, funct, zero, i, obs, q[i]);
                end
                @(negedge clk);
            end
        end
        #1;
        n_checks++;
        if (obs !== fetch_word()) begin
            n_fail++;
            $display("FAIL random_end: got %h, expected %h", obs, fetch_word());
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_jump_gpin();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
